// File: rtl/geofence_poly.sv
// Point-in-convex-polygon engine: loads a point and N_VTX vertices, orders the
// vertices angularly around vertex 0, then tests the point against every edge.
module geofence_poly #(
    parameter int N_VTX          = 6,
    parameter int CW             = 10,
    parameter bit ON_EDGE_INSIDE = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [CW-1:0] X,
    input  logic [CW-1:0] Y,
    output logic          busy,
    output logic          valid,
    output logic          is_inside
);

    localparam int IW = $clog2(N_VTX);
    localparam int DW = CW + 1;
    localparam int PW = 2 * CW + 2;
    localparam int EW = 2 * CW + 3;

    localparam logic [IW-1:0] LAST    = IW'(N_VTX - 1);
    localparam logic [IW-1:0] LAST_I  = IW'(N_VTX - 2);
    localparam logic [IW-1:0] FIRST_I = IW'(1);
    localparam logic [IW-1:0] FIRST_J = IW'(2);

    typedef enum logic [2:0] {PT, LOAD, SORT, CALC, DONE} state_t;

    // (a-o) x (b-o); operands are widened so the result can never overflow
    function automatic logic signed [EW-1:0] cross3(
        input logic [CW-1:0] ox, input logic [CW-1:0] oy,
        input logic [CW-1:0] ax, input logic [CW-1:0] ay,
        input logic [CW-1:0] bx, input logic [CW-1:0] by
    );
        logic signed [DW-1:0] dax, day, dbx, dby;
        logic signed [PW-1:0] p1, p2;
        dax = $signed({1'b0, ax}) - $signed({1'b0, ox});
        day = $signed({1'b0, ay}) - $signed({1'b0, oy});
        dbx = $signed({1'b0, bx}) - $signed({1'b0, ox});
        dby = $signed({1'b0, by}) - $signed({1'b0, oy});
        p1  = PW'(dax) * PW'(dby);
        p2  = PW'(dbx) * PW'(day);
        return EW'(p1) - EW'(p2);
    endfunction

    state_t           state_reg, state_next;
    logic [IW-1:0]    cnt_reg, cnt_next;
    logic [IW-1:0]    si_reg, si_next;
    logic [IW-1:0]    sj_reg, sj_next;
    logic             pos_reg, pos_next;
    logic             neg_reg, neg_next;
    logic             zro_reg, zro_next;
    logic             busy_reg, busy_next;
    logic             valid_reg, valid_next;
    logic             inside_reg, inside_next;
    logic [CW-1:0]    px_reg, py_reg;
    logic [CW-1:0]    vx_cur [N_VTX];
    logic [CW-1:0]    vy_cur [N_VTX];

    logic             accept;
    logic             pt_en;
    logic             load_en;
    logic             swap_en;
    logic             verdict;
    logic [IW-1:0]    k_nxt;
    logic signed [EW-1:0] c_val;
    logic signed [EW-1:0] e_val;

    assign accept = in_valid & ~busy_reg;
    assign k_nxt  = (cnt_reg == LAST) ? '0 : cnt_reg + IW'(1);

    assign c_val = cross3(vx_cur[0], vy_cur[0],
                          vx_cur[si_reg], vy_cur[si_reg],
                          vx_cur[sj_reg], vy_cur[sj_reg]);
    assign e_val = cross3(vx_cur[cnt_reg], vy_cur[cnt_reg],
                          vx_cur[k_nxt], vy_cur[k_nxt],
                          px_reg, py_reg);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        si_next    = si_reg;
        sj_next    = sj_reg;
        pos_next   = pos_reg;
        neg_next   = neg_reg;
        zro_next   = zro_reg;
        pt_en      = 1'b0;
        load_en    = 1'b0;
        swap_en    = 1'b0;
        case (state_reg)
            PT: begin
                if (accept) begin
                    pt_en      = 1'b1;
                    state_next = LOAD;
                    cnt_next   = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    load_en = 1'b1;
                    if (cnt_reg == LAST) begin
                        state_next = SORT;
                        cnt_next   = '0;
                        si_next    = FIRST_I;
                        sj_next    = FIRST_J;
                    end else begin
                        cnt_next = cnt_reg + IW'(1);
                    end
                end
            end
            SORT: begin
                // Vj not strictly counter-clockwise of Vi: swap so slot i ends as the minimum
                swap_en = c_val[EW-1] | (c_val == '0);
                if (sj_reg == LAST) begin
                    if (si_reg == LAST_I) begin
                        state_next = CALC;
                        cnt_next   = '0;
                        pos_next   = 1'b0;
                        neg_next   = 1'b0;
                        zro_next   = 1'b0;
                    end else begin
                        si_next = si_reg + IW'(1);
                        sj_next = si_reg + IW'(2);
                    end
                end else begin
                    sj_next = sj_reg + IW'(1);
                end
            end
            CALC: begin
                pos_next = pos_reg | (~e_val[EW-1] & (e_val != '0));
                neg_next = neg_reg | e_val[EW-1];
                zro_next = zro_reg | (e_val == '0);
                cnt_next = k_nxt;
                if (cnt_reg == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = PT;
            end
            default: begin
                state_next = PT;
            end
        endcase

        if (ON_EDGE_INSIDE) begin
            verdict = pos_next ^ neg_next;
        end else begin
            verdict = ~zro_next & ~(pos_next & neg_next);
        end
        busy_next   = (state_next == SORT) || (state_next == CALC) || (state_next == DONE);
        valid_next  = (state_next == DONE);
        inside_next = valid_next & verdict;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= PT;
            cnt_reg    <= '0;
            si_reg     <= '0;
            sj_reg     <= '0;
            pos_reg    <= 1'b0;
            neg_reg    <= 1'b0;
            zro_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            valid_reg  <= 1'b0;
            inside_reg <= 1'b0;
            px_reg     <= '0;
            py_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            si_reg     <= si_next;
            sj_reg     <= sj_next;
            pos_reg    <= pos_next;
            neg_reg    <= neg_next;
            zro_reg    <= zro_next;
            busy_reg   <= busy_next;
            valid_reg  <= valid_next;
            inside_reg <= inside_next;
            if (pt_en) begin
                px_reg <= X;
                py_reg <= Y;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_VTX; gi++) begin : g_vtx
            logic [CW-1:0] x_reg, y_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    x_reg <= '0;
                    y_reg <= '0;
                end else if (load_en && cnt_reg == IW'(gi)) begin
                    x_reg <= X;
                    y_reg <= Y;
                end else if (swap_en && si_reg == IW'(gi)) begin
                    x_reg <= vx_cur[sj_reg];
                    y_reg <= vy_cur[sj_reg];
                end else if (swap_en && sj_reg == IW'(gi)) begin
                    x_reg <= vx_cur[si_reg];
                    y_reg <= vy_cur[si_reg];
                end
            end
            assign vx_cur[gi] = x_reg;
            assign vy_cur[gi] = y_reg;
        end
    endgenerate

    assign busy      = busy_reg;
    assign valid     = valid_reg;
    assign is_inside = inside_reg;

endmodule

// File: tb/tb_geofence_poly.sv
// Bench for geofence_poly: fixed vector table, stall/junk/reset sequences and
// random convex polygons checked against an order-free hull-edge model.
module tb_geofence_poly;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] iv;
    logic [9:0] X, Y;
    logic [4:0] busy_v, valid_v, ins_v;

    always #5 clk = ~clk;

    // 0: N6 strict, 1: N4 strict, 2: N4 on-edge-inside, 3: N8 strict, 4: N3 strict
    geofence_poly #(.N_VTX(6), .CW(10), .ON_EDGE_INSIDE(1'b0)) u6 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .X(X), .Y(Y),
        .busy(busy_v[0]), .valid(valid_v[0]), .is_inside(ins_v[0]));
    geofence_poly #(.N_VTX(4), .CW(10), .ON_EDGE_INSIDE(1'b0)) u4a (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .X(X), .Y(Y),
        .busy(busy_v[1]), .valid(valid_v[1]), .is_inside(ins_v[1]));
    geofence_poly #(.N_VTX(4), .CW(10), .ON_EDGE_INSIDE(1'b1)) u4b (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .X(X), .Y(Y),
        .busy(busy_v[2]), .valid(valid_v[2]), .is_inside(ins_v[2]));
    geofence_poly #(.N_VTX(8), .CW(10), .ON_EDGE_INSIDE(1'b0)) u8 (
        .clk(clk), .reset(reset), .in_valid(iv[3]), .X(X), .Y(Y),
        .busy(busy_v[3]), .valid(valid_v[3]), .is_inside(ins_v[3]));
    geofence_poly #(.N_VTX(3), .CW(10), .ON_EDGE_INSIDE(1'b0)) u3 (
        .clk(clk), .reset(reset), .in_valid(iv[4]), .X(X), .Y(Y),
        .busy(busy_v[4]), .valid(valid_v[4]), .is_inside(ins_v[4]));

    typedef logic [7:0][9:0] crd8_t;
    typedef struct {
        int    sel;
        int    px;
        int    py;
        crd8_t vx;
        crd8_t vy;
        bit    expect_in;
    } vec_t;

    int n_of   [5] = '{6, 4, 4, 8, 3};
    bit oei_of [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int checks   = 0;
    int failures = 0;
    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, want);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic crd8_t pk8(input int a0, input int a1, input int a2, input int a3,
                                  input int a4, input int a5, input int a6, input int a7);
        crd8_t r;
        r[0] = 10'(a0); r[1] = 10'(a1); r[2] = 10'(a2); r[3] = 10'(a3);
        r[4] = 10'(a4); r[5] = 10'(a5); r[6] = 10'(a6); r[7] = 10'(a7);
        return r;
    endfunction

    function automatic vec_t mk(input int sel, input int px, input int py,
                                input crd8_t vx, input crd8_t vy, input bit e);
        vec_t v;
        v.sel = sel; v.px = px; v.py = py; v.vx = vx; v.vy = vy; v.expect_in = e;
        return v;
    endfunction

    function automatic int sgn(input longint v);
        return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    endfunction

    // Convex-hull view: every vertex pair with all others on one side is a boundary
    // edge, and the point must lie on that same side (or on it, when edges count as inside).
    function automatic bit ref_inside(input int n, input int px, input int py,
                                      input crd8_t vx, input crd8_t vy, input bit oei);
        bit ok = 1'b1;
        for (int a = 0; a < n; a++) begin
            for (int b = a + 1; b < n; b++) begin
                int  side = 0;
                bit  hull = 1'b1;
                longint ex = longint'(vx[b]) - longint'(vx[a]);
                longint ey = longint'(vy[b]) - longint'(vy[a]);
                for (int m = 0; m < n; m++) begin
                    if (m != a && m != b) begin
                        int s = sgn(ex * (longint'(vy[m]) - longint'(vy[a])) -
                                    ey * (longint'(vx[m]) - longint'(vx[a])));
                        if (s == 0) hull = 1'b0;
                        else if (side == 0) side = s;
                        else if (s != side) hull = 1'b0;
                    end
                end
                if (hull) begin
                    int sp = sgn(ex * (longint'(py) - longint'(vy[a])) -
                                 ey * (longint'(px) - longint'(vx[a])));
                    if (oei) begin
                        if (sp == -side) ok = 1'b0;
                    end else if (sp != side) begin
                        ok = 1'b0;
                    end
                end
            end
        end
        return ok;
    endfunction

    task automatic feed(input int sel, input int px, input int py,
                        input crd8_t vx, input crd8_t vy, input int gap_max, input string tag);
        int n = n_of[sel];
        for (int s = 0; s <= n; s++) begin
            int g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) begin
                step();
                iv = '0;
                X  = 10'($urandom);
                Y  = 10'($urandom);
            end
            step();
            if (s == n) check($sformatf("%s busy_at_last_vertex", tag), 32'(busy_v[sel]), 0);
            iv = 5'(1 << sel);
            X  = (s == 0) ? 10'(px) : vx[s-1];
            Y  = (s == 0) ? 10'(py) : vy[s-1];
        end
    endtask

    task automatic run_round(input int sel, input int px, input int py,
                             input crd8_t vx, input crd8_t vy, input int gap_max,
                             input bit junk, input bit expect_in, input string tag);
        int n  = n_of[sel];
        int sc = (n - 1) * (n - 2) / 2;
        int lat = sc + n + 1;
        int vcount = 0;
        int vd = -1;
        int badins = 0;
        logic got = 1'b0;
        logic b1 = 1'b0;
        logic bend = 1'b1;
        feed(sel, px, py, vx, vy, gap_max, tag);
        for (int d = 1; d <= lat + 1; d++) begin
            step();
            if (valid_v[sel]) begin
                vcount++;
                if (vd < 0) begin
                    vd  = d;
                    got = ins_v[sel];
                end
            end else if (ins_v[sel]) begin
                badins++;
            end
            if (d == 1) b1 = busy_v[sel];
            if (d == lat + 1) bend = busy_v[sel];
            iv = (junk && d <= lat && $urandom_range(1, 0) == 1) ? 5'(1 << sel) : '0;
            X  = 10'($urandom);
            Y  = 10'($urandom);
        end
        iv = '0;
        check($sformatf("%s busy_rise", tag), 32'(b1), 1);
        check($sformatf("%s latency", tag), 32'(vd), 32'(lat));
        check($sformatf("%s valid_width", tag), 32'(vcount), 1);
        check($sformatf("%s is_inside", tag), 32'(got), 32'(expect_in));
        check($sformatf("%s inside_without_valid", tag), 32'(badins), 0);
        check($sformatf("%s busy_fall", tag), 32'(bend), 0);
        $display("round %s sel=%0d P=(%0d,%0d) inside=%0d latency=%0d", tag, sel, px, py, got, vd);
    endtask

    task automatic reset_round(input int sel, input vec_t v, input int rd, input string tag);
        int n  = n_of[sel];
        int lat = (n - 1) * (n - 2) / 2 + n + 1;
        int vcount = 0;
        feed(sel, v.px, v.py, v.vx, v.vy, 0, tag);
        for (int d = 1; d <= lat + 2; d++) begin
            step();
            if (valid_v[sel]) vcount++;
            iv = '0;
            if (d == rd + 1) begin
                check($sformatf("%s outputs_after_reset", tag),
                      32'({busy_v[sel], valid_v[sel], ins_v[sel]}), 0);
                reset = 1'b0;
            end
            if (d == rd) reset = 1'b1;
        end
        check($sformatf("%s no_valid_after_abort", tag), 32'(vcount), 0);
        $display("abort %s sel=%0d reset_at=%0d valid_pulses=%0d", tag, sel, rd, vcount);
    endtask

    task automatic gen_poly(input int n, output crd8_t vx, output crd8_t vy);
        int xs [8];
        bit used [32];
        int k = 0;
        int kx, variant;
        for (int i = 0; i < 32; i++) used[i] = 1'b0;
        vx = '0;
        vy = '0;
        while (k < n) begin
            int x = int'($urandom_range(31, 0));
            if (!used[x]) begin
                used[x] = 1'b1;
                xs[k]   = x;
                k++;
            end
        end
        kx      = int'($urandom_range(32, 1));
        variant = int'($urandom_range(3, 0));
        // points on a parabola are always in strictly convex position
        for (int i = 0; i < n; i++) begin
            int xx = xs[i] * kx;
            int yy = xs[i] * xs[i];
            if (variant[0]) yy = 1023 - yy;
            if (variant[1]) begin
                int t = xx;
                xx = yy;
                yy = t;
            end
            vx[i] = 10'(xx);
            vy[i] = 10'(yy);
        end
        for (int i = n - 1; i > 0; i--) begin
            int j = int'($urandom_range(i, 0));
            logic [9:0] tx = vx[i];
            logic [9:0] ty = vy[i];
            vx[i] = vx[j]; vy[i] = vy[j];
            vx[j] = tx;    vy[j] = ty;
        end
    endtask

    initial begin
        crd8_t hx, hy, sqx, sqy, bqx, bqy, ox, oy, tx, ty, tcx, tcy;
        int sels [4] = '{0, 2, 3, 4};

        hx  = pk8(100, 0, 75, 25, 25, 75, 0, 0);
        hy  = pk8(50, 50, 93, 7, 93, 7, 0, 0);
        sqx = pk8(0, 100, 100, 0, 0, 0, 0, 0);
        sqy = pk8(0, 0, 100, 100, 0, 0, 0, 0);
        bqx = pk8(1023, 0, 1023, 0, 0, 0, 0, 0);
        bqy = pk8(1023, 0, 0, 1023, 0, 0, 0, 0);
        ox  = pk8(0, 1023, 300, 700, 1023, 0, 700, 300);
        oy  = pk8(300, 700, 1023, 0, 300, 700, 1023, 0);
        tx  = pk8(0, 1023, 0, 0, 0, 0, 0, 0);
        ty  = pk8(0, 0, 1023, 0, 0, 0, 0, 0);
        tcx = pk8(0, 0, 1023, 0, 0, 0, 0, 0);
        tcy = pk8(0, 1023, 0, 0, 0, 0, 0, 0);

        tbl[0]  = mk(0, 50, 50, hx, hy, 1'b1);
        tbl[1]  = mk(0, 100, 100, hx, hy, 1'b0);
        tbl[2]  = mk(1, 100, 40, sqx, sqy, 1'b0);
        tbl[3]  = mk(2, 100, 40, sqx, sqy, 1'b1);
        tbl[4]  = mk(2, 150, 0, sqx, sqy, 1'b0);
        tbl[5]  = mk(3, 512, 512, ox, oy, 1'b1);
        tbl[6]  = mk(3, 1023, 1023, ox, oy, 1'b0);
        tbl[7]  = mk(1, 1, 1022, bqx, bqy, 1'b1);
        tbl[8]  = mk(1, 0, 0, bqx, bqy, 1'b0);
        tbl[9]  = mk(2, 0, 0, bqx, bqy, 1'b1);
        tbl[10] = mk(4, 300, 300, tx, ty, 1'b1);
        tbl[11] = mk(4, 600, 600, tx, ty, 1'b0);
        tbl[12] = mk(4, 10, 10, tcx, tcy, 1'b1);

        reset = 1'b1;
        iv    = '0;
        X     = '0;
        Y     = '0;
        repeat (3) step();
        check("reset_state", 32'({busy_v, valid_v, ins_v}), 0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_round(tbl[i].sel, tbl[i].px, tbl[i].py, tbl[i].vx, tbl[i].vy,
                      0, 1'b0, tbl[i].expect_in, $sformatf("vec%0d", i));
        end

        run_round(0, 50, 50, hx, hy, 5, 1'b0, 1'b1, "stall");
        run_round(0, 50, 50, hx, hy, 0, 1'b1, 1'b1, "junk");
        run_round(0, 100, 100, hx, hy, 0, 1'b0, 1'b0, "after_junk");
        reset_round(0, tbl[0], 13, "rst_calc");
        run_round(0, 50, 50, hx, hy, 0, 1'b0, 1'b1, "fresh1");
        reset_round(0, tbl[0], 16, "rst_done");
        run_round(0, 50, 50, hx, hy, 0, 1'b0, 1'b1, "fresh2");
        reset_round(3, tbl[5], 25, "rst_calc8");
        run_round(3, 512, 512, ox, oy, 2, 1'b1, 1'b1, "fresh8");

        for (int r = 0; r < 16; r++) begin
            int sel = sels[r % 4];
            int n   = n_of[sel];
            int px, py;
            crd8_t rx, ry;
            bit e;
            gen_poly(n, rx, ry);
            if ($urandom_range(1, 0) == 1) begin
                int sx = 0, sy = 0;
                for (int i = 0; i < n; i++) begin
                    sx += int'(rx[i]);
                    sy += int'(ry[i]);
                end
                px = sx / n + int'($urandom_range(40, 0)) - 20;
                py = sy / n + int'($urandom_range(40, 0)) - 20;
                px = (px < 0) ? 0 : ((px > 1023) ? 1023 : px);
                py = (py < 0) ? 0 : ((py > 1023) ? 1023 : py);
            end else begin
                px = int'($urandom_range(1023, 0));
                py = int'($urandom_range(1023, 0));
            end
            e = ref_inside(n, px, py, rx, ry, oei_of[sel]);
            run_round(sel, px, py, rx, ry, 3, $urandom_range(1, 0) == 1, e,
                      $sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
